horner_stream_parser: RTL and testbench



---
 rtl/horner_pkg.sv | 28 ++
 rtl/horner_stream_parser.sv | 165 ++++++++++++++++
 tb/tb_horner_stream_parser.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/horner_pkg.sv
// Shared constants, write-target encodings and FSM state type for the
// Horner configuration stream parser.
package horner_pkg;

  // Point-set sizes of the evaluation core.
  localparam int ORI_NUM = 4;
  localparam int INT_NUM = 6;
  localparam int LAY_NUM = 2;

  // Beat counts of each frame section, derived from the point-set sizes.
  localparam int WEIGHT_NUM = 3 * ORI_NUM + INT_NUM - LAY_NUM + 3;
  localparam int MAT_NUM    = 3;
  localparam int VEC_NUM    = ORI_NUM + INT_NUM + LAY_NUM + 3;

  // Storage write targets.
  localparam logic [1:0] SEL_WGT = 2'd0;
  localparam logic [1:0] SEL_MAT = 2'd1;
  localparam logic [1:0] SEL_VEC = 2'd2;

  // Parser states: S_CAL waits for the header, the others walk the sections.
  typedef enum logic [1:0] {
    S_CAL = 2'd0,
    S_WGT = 2'd1,
    S_MAT = 2'd2,
    S_VEC = 2'd3
  } state_e;

endpackage

// File: rtl/horner_stream_parser.sv
// AXI4-Stream slave that turns one configuration frame (header, weights,
// matrix rows, point vectors) into registered storage writes, and flags
// frame completion or abort on an early tlast.
module horner_stream_parser
  import horner_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
) (
  input  logic                        s00_axis_aclk,
  input  logic                        s00_axis_aresetn,
  input  logic [LANES*DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                        s00_axis_tvalid,
  output logic                        s00_axis_tready,
  input  logic                        s00_axis_tlast,
  output logic [LANES*DATA_WIDTH-1:0] cal_num,
  output logic                        wr_en,
  output logic [1:0]                  wr_sel,
  output logic [4:0]                  wr_addr,
  output logic [LANES*DATA_WIDTH-1:0] wr_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam int BW = LANES * DATA_WIDTH;

  localparam logic [4:0] WGT_LAST = 5'(WEIGHT_NUM - 1);
  localparam logic [4:0] MAT_LAST = 5'(MAT_NUM - 1);
  localparam logic [4:0] VEC_LAST = 5'(VEC_NUM - 1);

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [BW-1:0]   cal_num_q, cal_num_d;
  logic            wr_en_q, wr_en_d;
  logic [1:0]      wr_sel_q, wr_sel_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [BW-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept_s;
  logic            sec_last_s;
  logic [1:0]      sec_sel_s;

  // The parser never backpressures; ready simply follows reset.
  assign s00_axis_tready = s00_axis_aresetn;
  assign accept_s        = s00_axis_tvalid & s00_axis_aresetn;

  // Per-section write target and terminal-index detection.
  always_comb begin
    sec_sel_s  = SEL_WGT;
    sec_last_s = 1'b0;
    case (state_q)
      S_WGT: begin
        sec_sel_s  = SEL_WGT;
        sec_last_s = (idx_q == WGT_LAST);
      end
      S_MAT: begin
        sec_sel_s  = SEL_MAT;
        sec_last_s = (idx_q == MAT_LAST);
      end
      S_VEC: begin
        sec_sel_s  = SEL_VEC;
        sec_last_s = (idx_q == VEC_LAST);
      end
      default: begin
        sec_sel_s  = SEL_WGT;
        sec_last_s = 1'b0;
      end
    endcase
  end

  // Next-state, index and output-register logic for the frame walker.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cal_num_d = cal_num_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (!accept_s) begin
      state_d = state_q;
    end else if (state_q == S_CAL) begin
      // Header beat: latch it, no storage write.
      cal_num_d = s00_axis_tdata;
      idx_d     = 5'd0;
      if (s00_axis_tlast) begin
        err_d   = 1'b1;
        state_d = S_CAL;
      end else begin
        state_d = S_WGT;
      end
    end else begin
      // Payload beat: the write is issued even if this beat aborts the frame.
      wr_en_d   = 1'b1;
      wr_sel_d  = sec_sel_s;
      wr_addr_d = idx_q;
      wr_data_d = s00_axis_tdata;
      if (s00_axis_tlast && !(state_q == S_VEC && sec_last_s)) begin
        err_d   = 1'b1;
        idx_d   = 5'd0;
        state_d = S_CAL;
      end else if (sec_last_s) begin
        idx_d = 5'd0;
        case (state_q)
          S_WGT:   state_d = S_MAT;
          S_MAT:   state_d = S_VEC;
          S_VEC: begin
            state_d = S_CAL;
            done_d  = 1'b1;
          end
          default: state_d = S_CAL;
        endcase
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end

    // Busy tracks the registered state, so it drops together with done/err.
    busy_d = (state_d != S_CAL);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q   <= S_CAL;
      idx_q     <= 5'd0;
      cal_num_q <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 2'd0;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cal_num_q <= cal_num_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cal_num    = cal_num_q;
  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_horner_stream_parser.sv
// Scoreboard bench for horner_stream_parser: each driven payload beat pushes
// its expected write; the monitor pops and compares on every wr_en.
module tb_horner_stream_parser;

  localparam int NW = 19;
  localparam int NM = 3;
  localparam int NV = 15;
  localparam int NBEATS = 1 + NW + NM + NV;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        done;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [63:0] cal_num;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  exp_t exp_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   cyc = 0;
  int   wr_total = 0;
  int   done_total = 0;
  int   err_total = 0;
  int   done_cyc = -1;
  bit   b2b_armed = 1'b0;

  horner_stream_parser dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (tdata),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tready  (tready),
    .s00_axis_tlast   (tlast),
    .cal_num          (cal_num),
    .wr_en            (wr_en),
    .wr_sel           (wr_sel),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_err        (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every write against the scoreboard, flag stray pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_total++;
        if (frame_done) begin
          done_total++;
          done_cyc = cyc;
        end
        if (frame_err) err_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_sel", {62'd0, wr_sel}, {62'd0, e.sel});
          chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
          chk("wr_data", wr_data, e.data);
          chk("frame_done", {63'd0, frame_done}, {63'd0, e.done});
          chk("frame_err", {63'd0, frame_err}, {63'd0, e.err});
          chk("busy", {63'd0, busy}, {63'd0, !(e.done || e.err)});
        end
        if (b2b_armed && wr_sel == 2'd0 && wr_addr == 5'd0) begin
          chk("b2b_gap", 64'(cyc - done_cyc), 64'd2);
          b2b_armed = 1'b0;
        end
      end else if (frame_done || frame_err) begin
        chk("pulse_without_write", {62'd0, frame_done, frame_err}, 64'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    chk({tag, "_wr_sel"}, {62'd0, wr_sel}, 64'd0);
    chk({tag, "_wr_addr"}, {59'd0, wr_addr}, 64'd0);
    chk({tag, "_wr_data"}, wr_data, 64'd0);
    chk({tag, "_cal_num"}, cal_num, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done_err"}, {62'd0, frame_done, frame_err}, 64'd0);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame. tlast_beat/rst_beat < 0 disable abort/reset; a gap of
  // gap_len idle cycles follows beat gap_after.
  task automatic send_frame(input logic [63:0] cal, input int tlast_beat,
                            input int gap_after, input int gap_len,
                            input int rst_beat, input bit b2b);
    logic [63:0] beats[NBEATS];
    int start_cyc;
    beats[0] = cal;
    for (int i = 0; i < NW; i++) beats[1+i] = {32'h0000_0000, 16'h0A00, 16'(i)};
    beats[2] = 64'hFFFF_FFFF_FFFD_9B18;
    beats[1+NW] = 64'hB000_0000_0000_0029;
    beats[2+NW] = {$urandom, $urandom};
    beats[3+NW] = {$urandom, $urandom};
    for (int i = 0; i < NV; i++) beats[1+NW+NM+i] = {$urandom, $urandom};
    beats[NBEATS-1] = {16'd1, 16'd200, 16'd0, 16'd800};
    if (b2b) b2b_armed = 1'b1;
    start_cyc = cyc;
    for (int b = 0; b < NBEATS; b++) begin
      exp_t e;
      tdata  = beats[b];
      tvalid = 1'b1;
      tlast  = (b == tlast_beat) || (b == NBEATS - 1);
      if (b == rst_beat) begin
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_mid");
        chk("rst_tready", {63'd0, tready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        tvalid = 1'b0;
        tlast  = 1'b0;
        rst_n  = 1'b1;
        return;
      end
      if (b > 0) begin
        e.data = beats[b];
        e.err  = (b == tlast_beat);
        e.done = (b == NBEATS - 1) && !e.err;
        if (b <= NW) begin
          e.sel = 2'd0; e.addr = 5'(b - 1);
        end else if (b <= NW + NM) begin
          e.sel = 2'd1; e.addr = 5'(b - 1 - NW);
        end else begin
          e.sel = 2'd2; e.addr = 5'(b - 1 - NW - NM);
        end
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (b == 0) begin
        chk("cal_num", cal_num, cal);
        chk("busy_rise", {63'd0, busy}, 64'd1);
      end
      if (b == tlast_beat) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      if (b == gap_after) idle(gap_len);
    end
    chk("done_latency", frame_done ? 64'(cyc - start_cyc) : 64'd0, 64'(NBEATS + gap_len));
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    int w0;
    rst_n  = 1'b0;
    tdata  = 64'd0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);
    chk("tready", {63'd0, tready}, 64'd1);

    // Standard frame, CAL_NUM = 3.
    w0 = wr_total;
    send_frame(64'h3, -1, -1, 0, -1, 1'b0);
    idle(3);
    chk("frame1_writes", 64'(wr_total - w0), 64'd37);
    chk("frame1_busy_low", {63'd0, busy}, 64'd0);

    // Three frames separated by 50 idle cycles.
    w0 = wr_total;
    for (int f = 0; f < 3; f++) begin
      send_frame(64'(f + 10), -1, -1, 0, -1, 1'b0);
      idle(50);
    end
    chk("three_frames_writes", 64'(wr_total - w0), 64'd111);
    chk("three_frames_done", 64'(done_total), 64'd4);
    chk("three_frames_no_err", 64'(err_total), 64'd0);

    // tvalid dropped for 5 cycles after weight 7 (beat 8).
    send_frame(64'h77, -1, 8, 5, -1, 1'b0);
    idle(3);

    // tlast on matrix beat 1 aborts; next beat is a header.
    w0 = wr_total;
    send_frame(64'h55, 1 + NW + 1, -1, 0, -1, 1'b0);
    idle(2);
    chk("abort_writes", 64'(wr_total - w0), 64'(NW + 2));
    chk("abort_err", 64'(err_total), 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    send_frame(64'h66, -1, -1, 0, -1, 1'b0);
    idle(3);

    // Reset at vector beat 4, then a full frame.
    send_frame(64'h99, -1, -1, 0, 1 + NW + NM + 4, 1'b0);
    idle(2);
    send_frame(64'hABC, -1, -1, 0, -1, 1'b0);

    // Back-to-back frames, no idle gap.
    send_frame(64'h101, -1, -1, 0, -1, 1'b0);
    send_frame(64'h102, -1, -1, 0, -1, 1'b1);
    idle(4);
    chk("b2b_checked", {63'd0, b2b_armed}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("total_err", 64'(err_total), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
